window_loader: RTL and testbench
================================

Name: window_loader

Overview:
Parametrised successor to pixel_loader: converts a raster pixel stream into K x K neighbourhood windows for the filter stages (gaussian_filter, gradient_calculation, later NMS/hysteresis).
Generalises pixel width, image size and kernel size (3 or 5).
Adds a ready/valid backpressure handshake, explicit start-of-frame resync, and a last-window flag.
Drop-in for pixel_loader when PIXEL_W=8, K=3, IMG_W=512.

Parameters:
PIXEL_W, 8, bits per pixel
IMG_W, 512, pixels per row; must be >= K
IMG_H, 512, rows per frame; must be >= K
K, 3, window edge length; legal values 3 or 5 (elaboration error otherwise)

Ports:
clk  in  1  clock, rising edge
rstN  in  1  asynchronous active-low reset
pixel_in  in  PIXEL_W  raster pixel, row-major
pixel_in_valid  in  1  pixel_in is valid
pixel_in_sof  in  1  qualifies an accepted pixel as frame position (0,0)
pixel_in_ready  out  1  block can accept a pixel this cycle
window_out  out  K*K*PIXEL_W  window; element (i,j) at bits [(i*K+j)*PIXEL_W +: PIXEL_W]; i=0 is the top row, j=0 is the left column
window_out_valid  out  1  window_out is valid
window_out_last  out  1  window is the last of the frame (bottom-right)
window_out_ready  in  1  downstream accepts the window

Behaviour:
- Handshake rules
  - accept = pixel_in_valid && pixel_in_ready.
  - pixel_in_ready = !window_out_valid || window_out_ready (combinational).
  - window_out, window_out_valid and window_out_last hold stable while window_out_valid && !window_out_ready.
- Position counters
  - col (0..IMG_W-1) and row (0..IMG_H-1) track the position of the next accepted pixel.
  - On accept: col increments. At IMG_W-1, col wraps to 0 and row increments. At (IMG_H-1, IMG_W-1), both wrap to 0 (next frame).
  - Accept with pixel_in_sof=1: the pixel is treated as (0,0), and the counters then advance from there. This resyncs mid-frame; no window is emitted for the abandoned partial frame beyond those already registered.
- Storage
  - K-1 line buffers, each IMG_W deep, PIXEL_W wide, cascaded.
  - On every accept, each buffer shifts one entry. The buffers are never cleared; stale data is harmless because output is suppressed.
  - A K x K window register shifts left by one column on each accept. The new right column is {line_buffer taps oldest..newest, pixel_in}, with row 0 being the oldest line.
- Output generation
  - An accept at (row,col) with row >= K-1 and col >= K-1 registers a window.
  - window_out_valid = 1 on the next cycle (latency 1 clk from accept).
  - The window is centred on (row-(K-1)/2, col-(K-1)/2).
  - Windows whose columns straddle a row wrap are suppressed (col < K-1).
  - window_out_last = 1 only for the window from the accept at (IMG_H-1, IMG_W-1).
- Stall: if no accept occurs while a window is being consumed (window_out_ready=1), window_out_valid drops to 0.
- Windows per frame: (IMG_H-K+1)*(IMG_W-K+1). No padding; border pixels produce no centred window.
- Reset values
  - window_out_valid=0, window_out_last=0, window_out=0; row=col=0; window register=0.
  - pixel_in_ready=1 from the first cycle after reset.
  - Line buffer contents are don't-care (RAM-inferable).
- Reset mid-frame: all state returns to reset values immediately (async). The next accepted pixel is (0,0) regardless of sof.
- Simultaneous events
  - Downstream consumes and upstream supplies in the same cycle: full throughput, 1 window/clk.
  - sof asserted on the pixel at natural position (0,0): no effect beyond the normal wrap.

Decomposition:
- Package window_pkg:
  - function win_idx(i,j,K) returning the bit offset.
  - localparam LEGAL_K list.
  - typedef pixel_t (logic [PIXEL_W-1:0]) via a parametrised struct-free typedef in the module.
- Sub-module line_buffer:
  - Single-row delay, parameters DEPTH=IMG_W and WIDTH=PIXEL_W.
  - Ports clk, rstN, shift_en, din, dout.
  - Circular pointer, RAM-inferable.
  - Instantiated K-1 times via generate.

Test Plan:
1. K=3, IMG_W=8, IMG_H=6, pixel=row*8+col streamed with valid=1 and ready=1:
   - First window one clk after accepting pixel 18: element(0,0)=0, (1,1)=9, (2,2)=18.
   - Exactly 24 windows.
   - last=1 only on the window with (2,2)=47.
2. K=5, same image and stimulus:
   - First window after pixel 36: (0,0)=0, (2,2)=18, (4,4)=36.
   - Exactly 8 windows; last window has (4,4)=47.
3. Backpressure: K=3, hold window_out_ready=0 for 5 clks after the first window.
   - window_out stays constant and pixel_in_ready=0 throughout.
   - No pixels are lost; the total window sequence is identical to scenario 1.
4. Input bubbles: pixel_in_valid toggles 1,0,1,0.
   - Window contents are identical to scenario 1.
   - window_out_valid is never asserted in a cycle following a non-accept.
5. SOF resync: after 20 pixels, assert sof on the next pixel and restart the frame.
   - No window references pre-sof pixels.
   - 24 windows follow, matching scenario 1.
6. Async reset: deassert rstN mid-frame between clock edges.
   - valid and last clear immediately.
   - After release, the next full frame yields exactly 24 correct windows.

Source files
------------

// File: rtl/window_pkg.sv
// Shared constants and helpers for the K x K window loader.
package window_pkg;

    localparam int LEGAL_K [2] = '{3, 5};

    function automatic bit is_legal_k(input int k);
        return (k == LEGAL_K[0]) || (k == LEGAL_K[1]);
    endfunction

    // Bit offset of window element (i,j); i=0 is the top row, j=0 the left column.
    function automatic int win_idx(input int i, input int j, input int k, input int w);
        return (i * k + j) * w;
    endfunction

endpackage

// File: rtl/window_loader_line_buffer.sv
// One-row delay line: dout shows the pixel accepted exactly DEPTH accepts earlier.
module line_buffer #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    // The registered read stage supplies one cycle of delay, so the RAM holds DEPTH-1 entries.
    localparam int MEM_D = DEPTH - 1;
    localparam int PW    = (MEM_D > 1) ? $clog2(MEM_D) : 1;

    logic [WIDTH-1:0] r_mem [MEM_D];
    logic [PW-1:0]    r_ptr;
    logic [WIDTH-1:0] r_dout;

    // RAM contents are never reset; stale data is masked by the window position logic.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            r_mem[r_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_ptr  <= '0;
            r_dout <= '0;
        end else if (shift_en) begin
            r_dout <= r_mem[r_ptr];
            r_ptr  <= (r_ptr == PW'(MEM_D - 1)) ? '0 : r_ptr + 1'b1;
        end
    end

    assign dout = r_dout;

endmodule

// File: rtl/window_loader.sv
// Raster pixel stream to K x K neighbourhood windows with ready/valid on both sides,
// start-of-frame resync and a last-window flag.
module window_loader
    import window_pkg::*;
#(
    parameter int PIXEL_W = 8,
    parameter int IMG_W   = 512,
    parameter int IMG_H   = 512,
    parameter int K       = 3
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic [PIXEL_W-1:0]     pixel_in,
    input  logic                   pixel_in_valid,
    input  logic                   pixel_in_sof,
    output logic                   pixel_in_ready,
    output logic [K*K*PIXEL_W-1:0] window_out,
    output logic                   window_out_valid,
    output logic                   window_out_last,
    input  logic                   window_out_ready
);
    typedef logic [PIXEL_W-1:0] pixel_t;

    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int WIN_W = K * K * PIXEL_W;

    generate
        if (!is_legal_k(K)) begin : g_bad_k
            $error("window_loader: K must be 3 or 5");
        end
        if (IMG_W < K || IMG_H < K) begin : g_bad_dim
            $error("window_loader: image must be at least K x K");
        end
    endgenerate

    logic [CW-1:0]    r_col, w_col, w_col_next;
    logic [RW-1:0]    r_row, w_row, w_row_next;
    logic             w_accept, w_col_end, w_row_end, w_emit, w_last;
    logic             r_valid, r_last;
    logic [WIN_W-1:0] r_win, w_win_next;
    pixel_t           w_tap    [K-1];
    pixel_t           w_lb_din [K-1];
    pixel_t           w_newcol [K];

    assign pixel_in_ready = !r_valid || window_out_ready;

    always_comb begin
        w_accept   = pixel_in_valid && pixel_in_ready;
        // An sof pixel is frame position (0,0) whatever the counters say.
        w_col      = pixel_in_sof ? '0 : r_col;
        w_row      = pixel_in_sof ? '0 : r_row;
        w_col_end  = (w_col == CW'(IMG_W - 1));
        w_row_end  = (w_row == RW'(IMG_H - 1));
        w_col_next = w_col_end ? '0 : w_col + 1'b1;
        w_row_next = w_row;
        if (w_col_end) begin
            w_row_next = w_row_end ? '0 : w_row + 1'b1;
        end
        w_emit = (w_row >= RW'(K - 1)) && (w_col >= CW'(K - 1));
        w_last = w_col_end && w_row_end;
    end

    // Cascaded line buffers: tap gi holds the pixel gi+1 rows above the incoming one.
    generate
        for (genvar gi = 0; gi < K - 1; gi++) begin : g_lb
            if (gi == 0) begin : g_head
                assign w_lb_din[gi] = pixel_in;
            end else begin : g_chain
                assign w_lb_din[gi] = w_tap[gi-1];
            end

            line_buffer #(
                .DEPTH (IMG_W),
                .WIDTH (PIXEL_W)
            ) u_lb (
                .clk      (clk),
                .rstN     (rstN),
                .shift_en (w_accept),
                .din      (w_lb_din[gi]),
                .dout     (w_tap[gi])
            );

            assign w_newcol[gi] = w_tap[K-2-gi];
        end
    endgenerate

    assign w_newcol[K-1] = pixel_in;

    // Window shifts left one column; the fresh column enters on the right.
    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_row
            for (genvar gj = 0; gj < K; gj++) begin : g_col
                if (gj < K - 1) begin : g_shift
                    assign w_win_next[win_idx(gi, gj, K, PIXEL_W) +: PIXEL_W] =
                        r_win[win_idx(gi, gj + 1, K, PIXEL_W) +: PIXEL_W];
                end else begin : g_new
                    assign w_win_next[win_idx(gi, gj, K, PIXEL_W) +: PIXEL_W] = w_newcol[gi];
                end
            end
        end
    endgenerate

    // No accept can happen while a window is stalled, so r_win doubles as the output register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_col   <= '0;
            r_row   <= '0;
            r_win   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_accept) begin
            r_col   <= w_col_next;
            r_row   <= w_row_next;
            r_win   <= w_win_next;
            r_valid <= w_emit;
            r_last  <= w_emit && w_last;
        end else if (window_out_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign window_out       = r_win;
    assign window_out_valid = r_valid;
    assign window_out_last  = r_last;

endmodule

// File: tb/tb_window_loader.sv
// Scoreboard bench for window_loader: K=3 and K=5 instances on an 8x6 image,
// each with its own stimulus, reference model and monitor.
module tb_window_loader;

    localparam int W = 8;
    localparam int H = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int KG = (gi == 0) ? 3 : 5;
        localparam int WB = KG * KG * 8;
        localparam int NWIN = (H - KG + 1) * (W - KG + 1);

        logic          rst_n = 1'b0;
        logic [7:0]    pix   = '0;
        logic          pv    = 1'b0;
        logic          psof  = 1'b0;
        logic          pr;
        logic [WB-1:0] wo;
        logic          wv, wl;
        logic          wr    = 1'b1;

        logic          done      = 1'b0;
        logic          bp_rand   = 1'b0;
        logic          arm       = 1'b0;
        int            stall_cnt = 0;
        int            n_win     = 0;

        // Reference model: current frame image plus raster position of the next pixel.
        int            img [H][W];
        int            mr = 0;
        int            mc = 0;
        logic [WB:0]   exp_q [$];

        logic          prev_acc  = 1'b0;
        logic          prev_hold = 1'b0;
        logic [WB:0]   prev_win  = '0;

        window_loader #(
            .PIXEL_W (8),
            .IMG_W   (W),
            .IMG_H   (H),
            .K       (KG)
        ) u_dut (
            .clk              (clk),
            .rstN             (rst_n),
            .pixel_in         (pix),
            .pixel_in_valid   (pv),
            .pixel_in_sof     (psof),
            .pixel_in_ready   (pr),
            .window_out       (wo),
            .window_out_valid (wv),
            .window_out_last  (wl),
            .window_out_ready (wr)
        );

        task automatic model_accept(input logic [7:0] v, input logic s);
            logic [WB:0] e;
            if (s) begin
                mr = 0;
                mc = 0;
            end
            img[mr][mc] = int'(v);
            if (mr >= KG - 1 && mc >= KG - 1) begin
                e = '0;
                for (int i = 0; i < KG; i++)
                    for (int j = 0; j < KG; j++)
                        e[(i*KG+j)*8 +: 8] = 8'(img[mr-KG+1+i][mc-KG+1+j]);
                e[WB] = (mr == H - 1) && (mc == W - 1);
                exp_q.push_back(e);
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr++;
                if (mr == H) mr = 0;
            end
        endtask

        // Called at posedge+1; returns at posedge+1 after the pixel is accepted.
        task automatic send(input logic [7:0] v, input logic s);
            int   t;
            logic acc;
            pv = 1'b1; pix = v; psof = s; t = 0; acc = 1'b0;
            while (!acc && t < 100) begin
                @(negedge clk);
                acc = pr;
                @(posedge clk);
                if (acc) model_accept(v, s);
                #1;
                t++;
            end
            if (!acc) chk($sformatf("K%0d accept_timeout", KG), 256'(acc), 256'(1));
            pv = 1'b0; psof = 1'b0;
        endtask

        task automatic idle(input int n);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        endtask

        task automatic drain();
            int t = 0;
            pv = 1'b0;
            while (exp_q.size() != 0 && t < 500) begin
                idle(1);
                t++;
            end
            chk($sformatf("K%0d drain_left", KG), 256'(exp_q.size()), 256'(0));
        endtask

        // mode: 0 = pattern row*8+col, 1 = random; bubble: 0 none, 1 alternate, 2 random
        task automatic frame(input int mode, input logic sof_first, input int bubble);
            n_win = 0;
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    send((mode == 0) ? 8'(r * W + c) : 8'($urandom), sof_first && r == 0 && c == 0);
                    if (bubble == 1) idle(1);
                    else if (bubble == 2) idle($urandom_range(0, 2));
                end
            end
            drain();
            chk($sformatf("K%0d win_count", KG), 256'(n_win), 256'(NWIN));
        endtask

        task automatic check_reset_state();
            chk($sformatf("K%0d rst_valid", KG), 256'(wv), 256'(0));
            chk($sformatf("K%0d rst_last", KG), 256'(wl), 256'(0));
            chk($sformatf("K%0d rst_window", KG), 256'(wo), 256'(0));
            chk($sformatf("K%0d rst_ready", KG), 256'(pr), 256'(1));
        endtask

        // Downstream ready: always 1, random, or a forced 5-cycle stall on the next window.
        always @(posedge clk) begin
            #1;
            if (arm && wv) begin
                arm = 1'b0;
                stall_cnt = 5;
            end
            if (stall_cnt > 0) begin
                wr = 1'b0;
                stall_cnt--;
            end else begin
                wr = bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end

        // Monitor: outputs sampled on the falling edge, away from the active edge.
        always @(negedge clk) begin
            logic [WB:0] e;
            if (!rst_n) begin
                prev_acc  = 1'b0;
                prev_hold = 1'b0;
            end else begin
                chk($sformatf("K%0d ready_rule", KG), 256'(pr), 256'(!wv || wr));
                if (wv) begin
                    chk($sformatf("K%0d valid_cause", KG), 256'(prev_acc || prev_hold), 256'(1));
                    if (prev_hold) chk($sformatf("K%0d hold_stable", KG), 256'({wl, wo}), 256'(prev_win));
                    if (wr) begin
                        if (exp_q.size() == 0) begin
                            chk($sformatf("K%0d unexpected_window", KG), 256'(wv), 256'(0));
                        end else begin
                            e = exp_q.pop_front();
                            chk($sformatf("K%0d window", KG), 256'({wl, wo}), 256'(e));
                            n_win++;
                            $display("[K%0d] window %0d last=%0b tl=%0d br=%0d", KG, n_win, wl,
                                     wo[7:0], wo[WB-1 -: 8]);
                        end
                    end
                end
                prev_acc  = pv && pr;
                prev_hold = wv && !wr;
                prev_win  = {wl, wo};
            end
        end

        initial begin
            rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            idle(1);
            check_reset_state();

            frame(0, 1'b0, 0);              // plain stream
            arm = 1'b1;
            frame(0, 1'b0, 0);              // 5-cycle stall on the first window
            frame(0, 1'b0, 1);              // alternating input bubbles
            for (int p = 0; p < 20; p++) send(8'($urandom), 1'b0);
            drain();
            frame(1, 1'b1, 0);              // sof resync mid-frame
            bp_rand = 1'b1;
            frame(1, 1'b0, 2);              // random data, bubbles and backpressure
            bp_rand = 1'b0;

            for (int p = 0; p < 30; p++) send(8'(p), 1'b0);
            #2 rst_n = 1'b0;                // async reset between clock edges
            #1;
            chk($sformatf("K%0d async_valid", KG), 256'(wv), 256'(0));
            chk($sformatf("K%0d async_last", KG), 256'(wl), 256'(0));
            exp_q.delete();
            mr = 0;
            mc = 0;
            idle(2);
            check_reset_state();
            rst_n = 1'b1;
            idle(1);
            frame(0, 1'b0, 0);
            done = 1'b1;
        end
    end

    initial begin
        int t = 0;
        while (!(g_dut[0].done && g_dut[1].done) && t < 50000) begin
            @(posedge clk);
            t++;
        end
        if (!(g_dut[0].done && g_dut[1].done)) begin
            n_checks++;
            n_fail++;
            $display("FAIL global_timeout: got not done, expected done");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
